// File: rtl/exp_bf16_pkg.sv
// Shared types, constants and segment tables for the bf16 exp pipeline.
// Tables hold bf16 exp(+/-2^(e-127)) bases and slopes to the next segment.
package exp_bf16_pkg;

  localparam logic [15:0] BF16_ONE  = 16'h3F80;
  localparam logic [15:0] BF16_PINF = 16'h7F80;
  localparam logic [15:0] BF16_MAXF = 16'h7F7F;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;

  localparam int TBL_E_LO = 122;
  localparam int TBL_E_HI = 131;
  localparam int TBL_N    = TBL_E_HI - TBL_E_LO + 1;

  typedef struct packed {
    logic nan;
    logic ovf;
    logic unf;
  } exp_flags_t;

  typedef struct packed {
    logic [15:0]        base;
    logic signed [12:0] ofs;
  } exp_seg_t;

  // Last entry's slope targets exp(+/-32), the endpoint of the top segment.
  localparam exp_seg_t EXP_POS_TBL [TBL_N] = '{
    '{16'h3F84, 13'sd4},
    '{16'h3F88, 13'sd9},
    '{16'h3F91, 13'sd19},
    '{16'h3FA4, 13'sd47},
    '{16'h3FD3, 13'sd91},
    '{16'h402E, 13'sd190},
    '{16'h40EC, 13'sd366},
    '{16'h425A, 13'sd736},
    '{16'h453A, 13'sd1486},
    '{16'h4B08, 13'sd2952}
  };

  localparam exp_seg_t EXP_NEG_TBL [TBL_N] = '{
    '{16'h3F78, -13'sd8},
    '{16'h3F70, -13'sd14},
    '{16'h3F62, -13'sd27},
    '{16'h3F47, -13'sd44},
    '{16'h3F1B, -13'sd95},
    '{16'h3EBC, -13'sd177},
    '{16'h3E0B, -13'sd373},
    '{16'h3C96, -13'sd742},
    '{16'h39B0, -13'sd1470},
    '{16'h33F2, -13'sd2958}
  };

  function automatic exp_seg_t seg_lookup(
    input logic       s,
    input logic [3:0] k
  );
    exp_seg_t r;
    r = '0;
    if (k < 4'(TBL_N))
      r = s ? EXP_NEG_TBL[k] : EXP_POS_TBL[k];
    return r;
  endfunction

endpackage

// File: rtl/exp_bf16_if.sv
// Valid/ready bundle carrying operands in and results plus flags out.
// The block side is the slave; the producer/consumer side is the master.
interface exp_bf16_if #(
  parameter int LANES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [16*LANES-1:0]    in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [16*LANES-1:0]    out_data;
  logic [3*LANES-1:0]     out_flags;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/exp_bf16_lane.sv
// One lane of the bf16 exp datapath: classify/lookup, multiply, add/mux.
// All three register stages advance together on en.
module exp_bf16_lane
  import exp_bf16_pkg::*;
#(
  parameter int E_LO       = 122,
  parameter int E_HI       = 131,
  parameter bit SAT_FINITE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [15:0] x,
  output logic [15:0] y,
  output exp_flags_t flags
);

  logic       s;
  logic [7:0] e;
  logic [6:0] m;
  assign {s, e, m} = x;

  logic c_nan, c_pinf, c_ninf;
  logic c_lo, c_povf, c_nunf;
  assign c_nan  = (e == 8'hFF) && (m != 7'd0);
  assign c_pinf = (e == 8'hFF) && (m == 7'd0) && !s;
  assign c_ninf = (e == 8'hFF) && (m == 7'd0) && s;
  assign c_lo   = e < 8'(E_LO);
  assign c_povf = (e != 8'hFF) && (e > 8'(E_HI)) && !s;
  assign c_nunf = (e != 8'hFF) && (e > 8'(E_HI)) && s;

  logic       sp;
  logic [15:0] sp_y;
  exp_flags_t sp_f;
  exp_seg_t   seg;

  always_comb begin
    sp   = 1'b1;
    sp_y = '0;
    sp_f = '0;
    unique case (1'b1)
      c_nan: begin
        sp_y     = BF16_QNAN;
        sp_f.nan = 1'b1;
      end
      c_pinf: begin
        sp_y     = BF16_PINF;
        sp_f.ovf = 1'b1;
      end
      c_ninf: sp_f.unf = 1'b1;
      c_lo:   sp_y = BF16_ONE;
      c_povf: begin
        sp_y     = SAT_FINITE ? BF16_MAXF : BF16_PINF;
        sp_f.ovf = 1'b1;
      end
      c_nunf: sp_f.unf = 1'b1;
      default: sp = 1'b0;
    endcase
  end

  assign seg = sp ? '0
             : seg_lookup(s, 4'(e - 8'(TBL_E_LO)));

  logic               s0_sp;
  logic [15:0]        s0_y;
  exp_flags_t         s0_f;
  logic [15:0]        s0_base;
  logic signed [12:0] s0_ofs;
  logic [6:0]         s0_m;

  logic               s1_sp;
  logic [15:0]        s1_y;
  exp_flags_t         s1_f;
  logic [15:0]        s1_base;
  logic signed [19:0] s1_prod;

  logic signed [19:0] prod;
  logic [15:0]        sum;

  assign prod = $signed({{7{s0_ofs[12]}}, s0_ofs})
              * $signed({13'b0, s0_m});

  // Arithmetic shift floors; wraparound of the add is the intended truncation.
  assign sum = s1_base + 16'(s1_prod >>> 7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_sp   <= 1'b0;
      s0_y    <= '0;
      s0_f    <= '0;
      s0_base <= '0;
      s0_ofs  <= '0;
      s0_m    <= '0;
      s1_sp   <= 1'b0;
      s1_y    <= '0;
      s1_f    <= '0;
      s1_base <= '0;
      s1_prod <= '0;
      y       <= '0;
      flags   <= '0;
    end else if (en) begin
      s0_sp   <= sp;
      s0_y    <= sp_y;
      s0_f    <= sp_f;
      s0_base <= seg.base;
      s0_ofs  <= seg.ofs;
      s0_m    <= m;
      s1_sp   <= s0_sp;
      s1_y    <= s0_y;
      s1_f    <= s0_f;
      s1_base <= s0_base;
      s1_prod <= prod;
      y       <= s1_sp ? s1_y : sum;
      flags   <= s1_sp ? s1_f : '0;
    end
  end

endmodule

// File: rtl/exp_bf16_pipe.sv
// Multi-lane pipelined bf16 exp approximator with valid/ready flow control.
// A single enable moves every stage, so bubbles stay where they are.
module exp_bf16_pipe
  import exp_bf16_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int E_LO       = 122,
  parameter int E_HI       = 131,
  parameter bit SAT_FINITE = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  exp_bf16_if.slave  bus
);

  if (E_LO < TBL_E_LO || E_HI > TBL_E_HI || E_HI < E_LO) begin : g_bad
    $error("exp_bf16_pipe: E_LO/E_HI outside segment table");
  end

  logic adv;
  logic v0, v1, v2;

  assign adv          = !v2 || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (adv) begin
      v0 <= bus.in_valid;
      v1 <= v0;
      v2 <= v1;
    end
  end

  logic [15:0] y_l [LANES];
  exp_flags_t  f_l [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    exp_bf16_lane #(
      .E_LO       (E_LO),
      .E_HI       (E_HI),
      .SAT_FINITE (SAT_FINITE)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .x     (bus.in_data[16*i +: 16]),
      .y     (y_l[i]),
      .flags (f_l[i])
    );
    assign bus.out_data[16*i +: 16] = y_l[i];
    assign bus.out_flags[3*i +: 3]  = f_l[i];
  end

endmodule

// File: doc/exp_bf16_pipe.md
Name: exp_bf16_pipe

Overview:
- Pipelined, multi-lane bfloat16 exp(x) approximator; successor to the single-lane combinational-lookup exp block.
- Per-exponent piecewise-linear interpolation on the bf16 bit pattern, with separate positive and negative segment tables.
- Adds full special-value handling, valid/ready back-pressure, per-lane status flags and a selectable overflow mode.
- Sits between the activation/softmax datapath and the output buffer.

Parameters:
- LANES, 4, number of parallel bf16 lanes sharing one handshake.
- E_LO, 122, lowest biased exponent with a table segment; below it the result is 1.0.
- E_HI, 131, highest biased exponent with a table segment; above it the result is overflow or underflow.
- SAT_FINITE, 0, 1 makes positive overflow return 0x7F7F (max finite); 0 makes it return 0x7F80 (+Inf).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  16*LANES  bf16 operands; lane i is [16i+15:16i].
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  16*LANES  bf16 results.
- out_flags  out  3*LANES  per lane {nan, ovf, unf}.

Behaviour:
- Interface: one clock, clk; reset is rst_n, synchronous and active-low. On reset all stage valids clear, out_valid=0, out_data=0, out_flags=0.
- Reset mid-operation: in-flight beats are discarded, with no partial output.
- Pipeline: 3 stages, latency 3 cycles from accepted input to out_valid when not stalled.
  - S0: field split, classify, table lookup.
  - S1: multiply.
  - S2: add and special-case mux.
- Flow control: global enable adv = !out_valid | out_ready; in_ready = adv.
  - All stages shift together only when adv=1.
  - Bubbles are not compressed.
  - Beats are accepted only on in_valid & in_ready.
  - No beat is lost or duplicated.
  - out_data and out_flags stay stable while out_valid & !out_ready.
- Per-lane fields: s=bit15, e=bits14:7, m=bits6:0. Classification, first match wins:
  - e=255, m!=0: result 0x7FC0, nan=1.
  - e=255, m=0, s=0: result 0x7F80, ovf=1.
  - e=255, m=0, s=1: result 0x0000, unf=1.
  - e<E_LO, including zero and denormals: result 0x3F80.
  - e>E_HI, s=0: result 0x7F7F if SAT_FINITE else 0x7F80, ovf=1.
  - e>E_HI, s=1: result 0x0000, unf=1.
  - Otherwise interpolate.
- Interpolation:
  - k=e-E_LO.
  - result = BASE[s][k] + ((OFS[s][k]*m) >>> 7).
  - OFS is signed 13-bit; the product is signed 20-bit; the shift is arithmetic (floor).
  - The sum is computed in 17-bit signed and truncated to 16 bits.
- Table contents:
  - BASE[s][k] = bf16 of exp(±2^(e-127)), rounded to nearest even.
  - OFS[s][k] = BASE at exponent e+1 minus BASE[s][k], as bit-pattern integers.
  - At k=E_HI-E_LO the endpoint is the bf16 of exp(±2^(E_HI-126)), rounded to nearest even.
- Flags are one cycle-aligned with out_data and zero for normal interpolation and 1.0 results.
- Lanes are fully independent; one NaN lane does not affect the others.

Decomposition:
- Package exp_bf16_pkg holds:
  - constants BF16_ONE=0x3F80, BF16_PINF=0x7F80, BF16_MAXF=0x7F7F, BF16_QNAN=0x7FC0;
  - the flag field struct {nan, ovf, unf};
  - the segment entry typedef {base 16b, ofs signed 13b};
  - the generated constant arrays EXP_POS_TBL and EXP_NEG_TBL, indexed by k, sized for the default E_LO..E_HI. Elaboration errors if the parameters exceed the table.
- Sub-module exp_bf16_lane: one lane's datapath across S0–S2 with its stage enable as an input.
- The top level owns the handshake and valid pipeline and generates LANES instances.

Test Plan:
- Reset, then x=0x3F80 (1.0) on all lanes with out_ready=1: out_valid rises 3 cycles after acceptance, data=0x402E, flags=0.
- x=0x3F00 (0.5) gives 0x3FD3; x=0xBF80 (-1.0) gives 0x3EBC; x=0x0000 and 0x3C00 give 0x3F80.
- Specials in lanes 0–3 = {0x7FC1, 0x7F80, 0xFF80, 0x42C8 (100.0)}: results {0x7FC0, 0x7F80, 0x0000, 0x7F80}, flags {nan, ovf, unf, ovf}. Repeat with SAT_FINITE=1: lane 3 gives 0x7F7F.
- Back-to-back stream of 10 beats with out_ready low for cycles 4–7:
  - in_ready drops while the output is held;
  - out_data is stable across the stall;
  - all 10 results arrive in order with no loss or duplication.
- Assert rst_n=0 for one cycle with 3 beats in flight: next cycle out_valid=0, out_data=0; no stale beat emerges afterwards.
- Sweep all 65536 inputs against a golden model using the package tables: exact bit match on every lane.
